dbus_traffic_gen: RTL and testbench

- Synthesizable, programmable stimulus engine for the CPU-side data-bus (dbiu) ports of the L0/L1 subsystem.
- Replaces hand-written per-CPU load sequences with a per-CPU op table of loads and stores.
- Drives N_CPU request/ack channels in either back-to-back (one CPU at a time) or concurrent mode.
- Checks read data against masked expected values and reports done, error count, first-error info and timeouts.

---
 rtl/dbus_traffic_gen.sv | 212 +++++++++++++++++++++
 tb/tb_dbus_traffic_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_traffic_gen.sv
// dbus_traffic_gen: table-driven load/store stimulus for the CPU data-bus channels,
// with masked read-data checking, per-channel timeouts and first-error capture.
module dbus_traffic_gen #(
    parameter int N_CPU     = 2,
    parameter int DBUS_AW   = 32,
    parameter int DBUS_DW   = 32,
    parameter int DBUS_ISEL = 4,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 256,
    parameter int GAP_CYC   = 1,
    localparam int CW = (N_CPU > 1) ? $clog2(N_CPU) : 1,
    localparam int IW = $clog2(DEPTH),
    localparam int LW = IW + 1,
    localparam int TW = $clog2(TIMEOUT + 1),
    localparam int GW = $clog2(GAP_CYC + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cfg_we,
    input  logic [CW-1:0]              cfg_cpu,
    input  logic [IW-1:0]              cfg_idx,
    input  logic                       cfg_op_we,
    input  logic [DBUS_AW-1:0]         cfg_adr,
    input  logic [DBUS_DW-1:0]         cfg_dat,
    input  logic [DBUS_ISEL-1:0]       cfg_sel,
    input  logic                       cfg_chk,
    input  logic [LW-1:0]              cfg_len,
    input  logic                       start,
    input  logic                       mode,
    output logic [N_CPU-1:0]           req_m2dbiu,
    output logic [N_CPU*DBUS_AW-1:0]   adr_m2dbiu_flat,
    output logic [N_CPU*DBUS_DW-1:0]   dat_m2dbiu_flat,
    output logic [N_CPU-1:0]           we_m2dbiu,
    output logic [N_CPU*DBUS_ISEL-1:0] sel_m2dbiu_flat,
    input  logic [N_CPU*DBUS_DW-1:0]   dat_dbiu2m_flat,
    input  logic [N_CPU-1:0]           ack_dbiu2m,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                err_cnt,
    output logic [N_CPU-1:0]           timeout,
    output logic [CW-1:0]              err_cpu,
    output logic [IW-1:0]              err_idx,
    output logic [DBUS_DW-1:0]         err_dat
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

    state_t             st_q   [N_CPU];
    state_t             st_d   [N_CPU];
    logic [LW-1:0]      cnt_q  [N_CPU];
    logic [LW-1:0]      cnt_d  [N_CPU];
    logic [LW-1:0]      len_q  [N_CPU];
    logic [LW-1:0]      len_d  [N_CPU];
    logic [TW-1:0]      tcnt_q [N_CPU];
    logic [TW-1:0]      tcnt_d [N_CPU];
    logic [GW-1:0]      gcnt_q [N_CPU];
    logic [GW-1:0]      gcnt_d [N_CPU];
    logic               busy_q, busy_d, done_q, done_d, mode_q, mode_d;
    logic [15:0]        err_cnt_q, err_cnt_d, nerr;
    logic [16:0]        sum;
    logic [N_CPU-1:0]   to_q, to_d;
    logic [CW-1:0]      ecpu_q, ecpu_d;
    logic [IW-1:0]      eidx_q, eidx_d;
    logic [DBUS_DW-1:0] edat_q, edat_d;
    logic               found, cfg_ok, start_ok;
    logic [N_CPU-1:0]   dn, prv, launch, mism, to_ev, err_ev;

    logic                 t_we  [N_CPU][DEPTH];
    logic                 t_chk [N_CPU][DEPTH];
    logic [DBUS_AW-1:0]   t_adr [N_CPU][DEPTH];
    logic [DBUS_DW-1:0]   t_dat [N_CPU][DEPTH];
    logic [DBUS_ISEL-1:0] t_sel [N_CPU][DEPTH];

    assign cfg_ok   = cfg_we && !busy_q;
    assign start_ok = start && !busy_q;
    assign prv      = dn << 1;

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            t_we[cfg_cpu][cfg_idx]  <= cfg_op_we;
            t_chk[cfg_cpu][cfg_idx] <= cfg_chk;
            t_adr[cfg_cpu][cfg_idx] <= cfg_adr;
            t_dat[cfg_cpu][cfg_idx] <= cfg_dat;
            t_sel[cfg_cpu][cfg_idx] <= cfg_sel;
        end
    end

    for (genvar c = 0; c < N_CPU; c++) begin : g_ch
        logic [IW-1:0]      ix;
        logic [DBUS_DW-1:0] rd, m;
        logic               iss;
        assign ix  = cnt_q[c][IW-1:0];
        assign iss = st_q[c] == S_ISSUE;
        assign rd  = dat_dbiu2m_flat[c*DBUS_DW +: DBUS_DW];
        // per-byte select doubles as the compare mask
        for (genvar b = 0; b < DBUS_ISEL; b++) begin : g_b
            assign m[b*8 +: 8] = {8{t_sel[c][ix][b]}};
        end
        assign mism[c]   = |((rd ^ t_dat[c][ix]) & m);
        assign dn[c]     = st_q[c] == S_DONE;
        assign launch[c] = busy_q ? (!mode_q && prv[c] && st_q[c] == S_IDLE) : (start_ok && (mode || c == 0));
        assign to_ev[c]  = iss && !ack_dbiu2m[c] && tcnt_q[c] == TW'(TIMEOUT - 1);
        assign err_ev[c] = to_ev[c] || (iss && ack_dbiu2m[c] && !t_we[c][ix] && t_chk[c][ix] && mism[c]);
        assign req_m2dbiu[c] = iss;
        assign we_m2dbiu[c]  = iss && t_we[c][ix];
        assign adr_m2dbiu_flat[c*DBUS_AW +: DBUS_AW]     = iss ? t_adr[c][ix] : '0;
        assign dat_m2dbiu_flat[c*DBUS_DW +: DBUS_DW]     = iss ? t_dat[c][ix] : '0;
        assign sel_m2dbiu_flat[c*DBUS_ISEL +: DBUS_ISEL] = iss ? t_sel[c][ix] : '0;
    end

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        len_d     = len_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mode_d    = mode_q;
        to_d      = to_q | to_ev;
        ecpu_d    = ecpu_q;
        eidx_d    = eidx_q;
        edat_d    = edat_q;
        nerr      = '0;
        found     = 1'b0;
        if (cfg_ok) len_d[cfg_cpu] = cfg_len;
        for (int c = 0; c < N_CPU; c++) begin
            unique case (st_q[c])
                S_IDLE: if (launch[c]) begin
                    st_d[c]   = (len_d[c] == '0) ? S_DONE : S_ISSUE;
                    cnt_d[c]  = '0;
                    tcnt_d[c] = '0;
                end
                S_ISSUE: if (ack_dbiu2m[c]) begin
                    st_d[c]   = S_GAP;
                    gcnt_d[c] = '0;
                end else if (to_ev[c]) st_d[c] = S_DONE;
                else tcnt_d[c] = tcnt_q[c] + TW'(1);
                S_GAP: if (gcnt_q[c] == GW'(GAP_CYC - 1)) begin
                    cnt_d[c]  = cnt_q[c] + LW'(1);
                    tcnt_d[c] = '0;
                    st_d[c]   = (cnt_q[c] + LW'(1) == len_q[c]) ? S_DONE : S_ISSUE;
                end else gcnt_d[c] = gcnt_q[c] + GW'(1);
                default: ;
            endcase
            if (err_ev[c]) begin
                nerr = nerr + 16'd1;
                if (!found && err_cnt_q == '0) begin
                    ecpu_d = CW'(c);
                    eidx_d = cnt_q[c][IW-1:0];
                    edat_d = to_ev[c] ? '0 : dat_dbiu2m_flat[c*DBUS_DW +: DBUS_DW];
                end
                found = 1'b1;
            end
        end
        sum       = {1'b0, err_cnt_q} + {1'b0, nerr};
        err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        if (busy_q && &dn) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            st_d   = '{default: S_IDLE};
        end
        if (start_ok) begin
            busy_d    = 1'b1;
            mode_d    = mode;
            to_d      = '0;
            err_cnt_d = '0;
            ecpu_d    = '0;
            eidx_d    = '0;
            edat_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st_q      <= '{default: S_IDLE};
            cnt_q     <= '{default: '0};
            len_q     <= '{default: '0};
            tcnt_q    <= '{default: '0};
            gcnt_q    <= '{default: '0};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            err_cnt_q <= '0;
            to_q      <= '0;
            ecpu_q    <= '0;
            eidx_q    <= '0;
            edat_q    <= '0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            err_cnt_q <= err_cnt_d;
            to_q      <= to_d;
            ecpu_q    <= ecpu_d;
            eidx_q    <= eidx_d;
            edat_q    <= edat_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign timeout = to_q;
    assign err_cpu = ecpu_q;
    assign err_idx = eidx_q;
    assign err_dat = edat_q;
endmodule

// File: tb/tb_dbus_traffic_gen.sv
// tb_dbus_traffic_gen: directed and randomized runs against a cycle-count and
// error-outcome model derived from the op table, with a latency-programmable bus responder.
module tb_dbus_traffic_gen;
    localparam int N = 2, AW = 32, DW = 32, IS = 4, D = 8, TO = 16, G = 1;

    logic            clk, resetn, cfg_we, cfg_op_we, cfg_chk, start, mode, busy, done;
    logic [0:0]      cfg_cpu, err_cpu;
    logic [2:0]      cfg_idx, err_idx;
    logic [AW-1:0]   cfg_adr;
    logic [DW-1:0]   cfg_dat, err_dat;
    logic [IS-1:0]   cfg_sel;
    logic [3:0]      cfg_len;
    logic [N-1:0]    req, we, ack, timeout;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] wdat, rdat;
    logic [N*IS-1:0] sel;
    logic [15:0]     err_cnt;

    int checks = 0, failures = 0;
    logic          tw [N][D];
    logic          tc [N][D];
    logic [31:0]   ta [N][D];
    logic [31:0]   td [N][D];
    logic [3:0]    ts [N][D];
    logic [31:0]   ret [N][D];
    int            tlen [N];
    int            lat [N];
    bit            spur, seqm;

    dbus_traffic_gen #(.N_CPU(N), .DBUS_AW(AW), .DBUS_DW(DW), .DBUS_ISEL(IS), .DEPTH(D),
                       .TIMEOUT(TO), .GAP_CYC(G)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_cpu(cfg_cpu), .cfg_idx(cfg_idx),
        .cfg_op_we(cfg_op_we), .cfg_adr(cfg_adr), .cfg_dat(cfg_dat), .cfg_sel(cfg_sel),
        .cfg_chk(cfg_chk), .cfg_len(cfg_len), .start(start), .mode(mode),
        .req_m2dbiu(req), .adr_m2dbiu_flat(adr), .dat_m2dbiu_flat(wdat), .we_m2dbiu(we),
        .sel_m2dbiu_flat(sel), .dat_dbiu2m_flat(rdat), .ack_dbiu2m(ack), .busy(busy),
        .done(done), .err_cnt(err_cnt), .timeout(timeout), .err_cpu(err_cpu),
        .err_idx(err_idx), .err_dat(err_dat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic bit mism(input logic [31:0] r, input logic [31:0] e, input logic [3:0] s);
        return ((r ^ e) & expand(s)) != 0;
    endfunction

    task automatic cfg(input int c, input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit ck, input int len, input bit hold);
        cfg_we = 1'b1; cfg_cpu = 1'(c); cfg_idx = 3'(i); cfg_op_we = w; cfg_adr = a;
        cfg_dat = d; cfg_sel = s; cfg_chk = ck; cfg_len = 4'(len);
        tw[c][i] = w; ta[c][i] = a; td[c][i] = d; ts[c][i] = s; tc[c][i] = ck; tlen[c] = len;
        if (!hold) begin
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
    endtask

    // expected end cycle and error outcome computed from op counts and latencies
    task automatic run(input bit m, input bit poke);
        int dur [N], et [N], ei [N], st, acc, errs, tdone, best, n, bc, bi;
        logic [31:0] ed [N], bd;
        logic [N-1:0] to;
        errs = 0; to = '0; best = 1 << 30; bc = 0; bi = 0; bd = 0; acc = 1; tdone = 0;
        for (int c = 0; c < N; c++) begin
            et[c] = -1; ei[c] = 0; ed[c] = 0;
            if (tlen[c] == 0) dur[c] = 0;
            else if (lat[c] == 0) begin
                dur[c] = TO; to[c] = 1'b1; errs++; et[c] = TO;
            end else begin
                dur[c] = tlen[c] * (lat[c] + G);
                for (int k = 0; k < tlen[c]; k++)
                    if (!tw[c][k] && tc[c][k] && mism(ret[c][k], td[c][k], ts[c][k])) begin
                        errs++;
                        if (et[c] < 0) begin
                            et[c] = k * (lat[c] + G) + lat[c]; ei[c] = k; ed[c] = ret[c][k];
                        end
                    end
            end
            st = m ? 1 : acc;
            acc = st + dur[c] + 1;
            if (st + dur[c] + 1 > tdone) tdone = st + dur[c] + 1;
            if (et[c] >= 0 && st + et[c] < best) begin
                best = st + et[c]; bc = c; bi = ei[c]; bd = ed[c];
            end
        end
        seqm = !m; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0; n = 1;
        check("busy_rise", busy, 1);
        while (done !== 1'b1 && n < 2000) begin
            if (poke && n == 2) begin
                cfg_we = 1'b1; cfg_cpu = 0; cfg_idx = 0; cfg_adr = 32'hBAD0BAD0; cfg_len = 4'd1; start = 1'b1;
            end else begin
                cfg_we = 1'b0; start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        cfg_we = 1'b0; start = 1'b0;
        check("done_cycle", 64'(n), 64'(tdone));
        check("busy_fall", busy, 0);
        check("err_cnt", err_cnt, 64'(errs));
        check("timeout", timeout, to);
        check("err_cpu", err_cpu, errs ? 64'(bc) : 0);
        check("err_idx", err_idx, errs ? 64'(bi) : 0);
        check("err_dat", err_dat, errs ? bd : 0);
        repeat (3) begin @(posedge clk); #1; end
        check("done_once", done, 0);
        check("no_rerun", busy, 0);
    endtask

    // bus responder: acks the lat-th cycle of each request, lat 0 never acks
    initial begin
        int k [N], w [N];
        ack = '0; rdat = '0;
        forever begin
            @(posedge clk); #2;
            for (int c = 0; c < N; c++) begin
                if (busy !== 1'b1) begin k[c] = 0; w[c] = 0; end
                if (req[c] === 1'b1) begin
                    if (w[c] == 0) begin
                        check("op_in_len", k[c] < tlen[c], 1);
                        check("req_adr", adr[c*AW +: AW], ta[c][k[c] % D]);
                        check("req_we", we[c], tw[c][k[c] % D]);
                        check("req_sel", sel[c*IS +: IS], ts[c][k[c] % D]);
                        if (tw[c][k[c] % D]) check("req_dat", wdat[c*DW +: DW], td[c][k[c] % D]);
                    end
                    w[c]++;
                    if (lat[c] != 0 && w[c] == lat[c]) begin
                        ack[c] = 1'b1;
                        rdat[c*DW +: DW] = tw[c][k[c] % D] ? $urandom : ret[c][k[c] % D];
                        k[c]++; w[c] = 0;
                    end else begin
                        ack[c] = 1'b0; rdat[c*DW +: DW] = $urandom;
                    end
                end else begin
                    if (busy === 1'b1)
                        check("idle_zero", {adr[c*AW +: AW], wdat[c*DW +: DW], we[c], sel[c*IS +: IS]}, 0);
                    ack[c] = spur && ($urandom_range(0, 1) == 1);
                    rdat[c*DW +: DW] = $urandom;
                end
            end
            if (seqm && busy === 1'b1) check("one_req", &req, 0);
        end
    end

    initial begin
        int n, len;
        logic [31:0] d, noise;
        logic [3:0] s;
        resetn = 1'b0; cfg_we = 0; cfg_cpu = 0; cfg_idx = 0; cfg_op_we = 0; cfg_adr = 0; cfg_dat = 0;
        cfg_sel = 0; cfg_chk = 0; cfg_len = 0; start = 0; mode = 0; spur = 0; seqm = 0;
        tlen = '{0, 0}; lat = '{1, 1};
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_to", timeout, 0);
        check("rst_req", req, 0);
        resetn = 1'b1;

        cfg(0, 0, 0, 32'h0, 32'hDEADBEEF, 4'hF, 1, 1, 0);
        cfg(1, 0, 0, 32'h0, 32'hDEADBEEF, 4'hF, 1, 1, 0);
        ret[0][0] = 32'hDEADBEEF; ret[1][0] = 32'hDEADBEEF; lat = '{3, 3};
        run(0, 0);

        cfg(0, 0, 0, 32'h0, 32'h0000BEEF, 4'b0011, 1, 1, 0);
        cfg(1, 0, 0, 32'h4, 32'h0, 4'hF, 1, 0, 0);
        ret[0][0] = 32'h1234BEEF;
        run(0, 0);
        ret[0][0] = 32'h1234BEEE;
        run(0, 0);

        cfg(0, 0, 1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
        cfg(0, 1, 0, 32'h10, 32'hA5A5A5A5, 4'hF, 1, 2, 0);
        cfg(1, 0, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
        cfg(1, 1, 0, 32'h20, 32'hA5A5A5A5, 4'hF, 1, 2, 0);
        ret[0][1] = 32'hA5A5A5A5; ret[1][1] = 32'hA5A5A5A5; lat = '{1, 1};
        run(1, 0);

        lat = '{2, 0};
        run(1, 0);
        lat = '{0, 2};
        run(0, 0);

        lat = '{5, 5}; mode = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        while (req[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("rst_req_seen", req[0], 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_we", we, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_cnt, 0);
        resetn = 1'b1;
        tlen = '{0, 0};
        run(0, 0);
        cfg(0, 0, 1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
        cfg(1, 0, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
        run(0, 0);

        lat = '{4, 4};
        run(0, 1);
        run(0, 0);
        cfg(1, 0, 0, 32'h30, 32'h0, 4'hF, 1, 0, 0);
        run(1, 0);
        run(0, 0);

        for (int r = 0; r < 20; r++) begin
            spur = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < N; c++) begin
                lat[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
                len = $urandom_range(0, D);
                for (int i = 0; i < ((len > 0) ? len : 1); i++) begin
                    d = $urandom; s = 4'($urandom_range(0, 15)); noise = $urandom;
                    case ($urandom_range(0, 2))
                        0: ret[c][i] = d;
                        1: ret[c][i] = d ^ (noise & ~expand(s));
                        default: ret[c][i] = d ^ noise;
                    endcase
                    cfg(c, i, $urandom_range(0, 1) == 1, $urandom, d, s, $urandom_range(0, 1) == 1, len,
                        c == N - 1 && i == ((len > 0) ? len : 1) - 1);
                end
            end
            run($urandom_range(0, 1) == 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
